// File: rtl/display_pkg.sv
// Shared types, font table and digit-search helper for the seven-segment
// scan controller.
package display_pkg;

    localparam int NUM_DIGITS = 8;

    typedef logic [6:0] seg_t;

    typedef enum logic [1:0] {
        BLANK,
        SHOW,
        IDLE
    } scan_state_t;

    // All segments dark (active-low).
    localparam seg_t SEG_OFF = 7'h7F;

    // Active-low hex font, segment order {g,f,e,d,c,b,a}, indexed by value.
    localparam seg_t FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Nearest enabled digit searching upward from 'from' with wrap. The
    // search starts at 'from' itself when 'inclusive' is set, else at from+1.
    // Returns 'from' when the mask is empty; callers screen that case first.
    function automatic logic [2:0] next_enabled(
        input logic [2:0]            from,
        input logic [NUM_DIGITS-1:0] mask,
        input logic                  inclusive
    );
        logic [2:0] idx;
        next_enabled = from;
        // Walk farthest-first so the nearest hit is the last assignment.
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            idx = from + 3'(k) + (inclusive ? 3'd0 : 3'd1);
            if (mask[idx]) begin
                next_enabled = idx;
            end
        end
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational 4-bit hex to active-low seven-segment decoder.
module hex_to_seg
    import display_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    assign seg = FONT[value];

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment scan controller. Each slot blanks
// all anodes for BLANK_CYCLES cycles while the digit mux settles, then shows
// the selected digit for the rest of the slot. Disabled digits are skipped.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100_000,
    parameter int BLANK_CYCLES = 1_000
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] digit_en,
    input  logic [7:0] dp_mask,
    input  logic [3:0] digit_val,
    output logic [2:0] sel,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int               CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_END  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [7:0]       AN_OFF    = 8'hFF;

    scan_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       sel_nxt;
    logic             en_q;
    logic             restart_hold;
    logic [7:0]       an_nxt;
    seg_t             seg_nxt, seg_dec;
    logic             dp_nxt, tick_nxt;

    hex_to_seg u_dec (
        .value (digit_val),
        .seg   (seg_dec)
    );

    // On the first enabled cycle the current digit may have been disabled
    // while paused: spend that cycle moving sel (or parking in IDLE) without
    // advancing the slot counter, so the new digit still gets a full blank.
    assign restart_hold = en && !en_q && (state == BLANK) && !digit_en[sel];

    // State, slot counter, digit select and enable history.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values and the evaluation order of blocks is irrelevant.
        if (reset) begin
            state <= BLANK;
            cnt   <= '0;
            sel   <= '0;
            en_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sel   <= sel_nxt;
            en_q  <= en;
        end
    end

    // Next state: slot sequencing, digit advance and idle handling.
    always_comb begin
        // NOTE: every signal gets a default before the branches so no path
        // leaves it unassigned, which would infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel;
        if (!en) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
        end else if (restart_hold) begin
            cnt_nxt = '0;
            if (digit_en == 8'h00) begin
                state_nxt = IDLE;
            end else begin
                sel_nxt = next_enabled(sel, digit_en, 1'b1);
            end
        end else begin
            unique case (state)
                BLANK: begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == BLANK_END) begin
                        state_nxt = SHOW;
                    end
                end
                SHOW: begin
                    if (cnt == SLOT_END) begin
                        cnt_nxt = '0;
                        if (digit_en == 8'h00) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = BLANK;
                            sel_nxt   = next_enabled(sel, digit_en, 1'b0);
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                IDLE: begin
                    cnt_nxt = '0;
                    if (digit_en != 8'h00) begin
                        state_nxt = BLANK;
                        sel_nxt   = next_enabled(sel, digit_en, 1'b1);
                    end
                end
                default: begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output decode: values loaded into the output registers on this edge.
    always_comb begin
        an_nxt   = an;
        seg_nxt  = seg;
        dp_nxt   = dp;
        tick_nxt = 1'b0;
        if (!en) begin
            an_nxt = AN_OFF;
        end else begin
            unique case (state)
                BLANK: begin
                    if (!restart_hold && cnt == BLANK_END) begin
                        seg_nxt = seg_dec;
                        dp_nxt  = ~dp_mask[sel];
                        an_nxt  = ~(8'b1 << sel);
                    end
                end
                SHOW: begin
                    if (cnt == SLOT_END) begin
                        an_nxt = AN_OFF;
                        // A non-increasing select means the scan wrapped.
                        if (digit_en != 8'h00) begin
                            tick_nxt = (sel_nxt <= sel);
                        end
                    end
                end
                default: begin
                    an_nxt = AN_OFF;
                end
            endcase
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_nxt;
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            frame_tick <= tick_nxt;
        end
    end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed 8-digit seven-segment scan controller for the stopwatch display. Drives the 3-bit digit select into the digit mux, takes back the selected 4-bit value, and converts it to segment patterns. It also generates active-low anode enables with inter-digit blanking to prevent ghosting. Sits between the stopwatch digit registers/mux and the board display pins.

## Interface
- REFRESH_DIV, 100_000: clock cycles per digit slot; must be at least 2.
- BLANK_CYCLES, 1_000: all-anodes-off cycles at the start of each slot; valid range is 1 to REFRESH_DIV-1.
- clk  in  1  system clock. One clock domain only.
- reset  in  1  reset; synchronous and active-high.
- en  in  1  scan enable.
- digit_en  in  8  per-digit enable mask; disabled digits are skipped.
- dp_mask  in  8  decimal point on for digit i when bit i is 1.
- digit_val  in  4  value returned by the digit mux for the current sel.
- sel  out  3  digit select to the mux.
- an  out  8  anode enables, active-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_tick  out  1  one-cycle pulse when the scan wraps.

## Operation
- Reset values: sel=0, an=8'hFF, seg=7'h7F, dp=1, frame_tick=0, cnt=0, state=BLANK.
- FSM states: BLANK, SHOW, IDLE.
- cnt is a slot counter, 0..REFRESH_DIV-1, width $clog2(REFRESH_DIV).
- Every slot is REFRESH_DIV cycles long: BLANK for BLANK_CYCLES cycles, then SHOW for the remainder.
- BLANK, at cnt==BLANK_CYCLES-1:
  - seg <= hex decode of digit_val.
  - dp <= ~dp_mask[sel].
  - an <= ~(8'b1 << sel).
  - Go to SHOW.
- SHOW, at cnt==REFRESH_DIV-1:
  - an <= 8'hFF, cnt <= 0.
  - sel <= next enabled index above sel, wrapping modulo 8.
  - Go to BLANK.
- frame_tick=1 on the cycle after sel is loaded with a value ≤ its previous value (wrap). With a single enabled digit, this pulses every slot.
- digit_en == 0 at slot end or at en rise: go to IDLE. In IDLE, an=8'hFF and sel holds.
- IDLE exits to BLANK when any digit_en bit is set. sel advances to the first enabled index ≥ current sel, with wrap.
- en=0: on the next edge, an=8'hFF, cnt=0, state=BLANK, sel holds, and seg/dp hold.
- en rising restarts a full slot at the current sel, or at the next enabled index if the current one is disabled.
- Changes to digit_en mid-slot do not affect the current slot. The mask is sampled only at slot end.
- dp_mask and digit_val are sampled only at the BLANK→SHOW edge.
- Decode table, hex 0–F, active-low:
  - 0 → 7'b1000000
  - 1 → 7'b1111001
  - 8 → 7'b0000000
  - A → 7'b0001000
  - F → 7'b0001110
  - Remaining values follow the standard hex font.
- reset overrides en.
- reset mid-slot returns all outputs to their reset values on the next edge.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- The mux is combinational: digit_val is valid in the same cycle as sel. It is sampled only after BLANK_CYCLES ≥ 1 cycles of settling.
- Anode on-time per slot: REFRESH_DIV − BLANK_CYCLES cycles.
- Anode off-time between adjacent digits: exactly BLANK_CYCLES cycles.
- At most one an bit is low at any cycle.
- Frame period: REFRESH_DIV × (number of enabled digits) cycles.

## Structure
- Package display_pkg holds:
  - NUM_DIGITS=8.
  - typedef enum logic [1:0] scan_state_t {BLANK, SHOW, IDLE}.
  - The 16-entry seg_t font constants.
  - SEG_OFF=7'h7F.
- Sub-module hex_to_seg: combinational 4→7 decoder using the package font.
- Top level contains the FSM, slot counter, next-enabled-index priority logic, and output registers.

## Test plan
All scenarios use REFRESH_DIV=8 and BLANK_CYCLES=2.
- Reset, en=1, digit_en=FF, digit_val=sel:
  - an=FF for 2 cycles, then FE for 6 cycles with seg=7'b1000000.
  - sel steps 0→7, then wraps.
  - frame_tick pulses once every 64 cycles.
- digit_en=8'b0010_0101:
  - sel sequence is 0,2,5,0.
  - an patterns are FE, FB, DF.
  - Frame period is 24 cycles.
- dp_mask=8'h04, digit_val=4'hF:
  - On digit 2: dp=0, seg=7'b0001110.
  - On all other digits: dp=1.
- en deasserted mid-SHOW on sel=3:
  - an=FF on the next edge.
  - After en rises: 2 blank cycles, then an=F7.
- digit_en=0:
  - IDLE, an held at FF.
  - Setting digit_en=8'h80: sel=7, an=7F after 2 cycles.
- reset asserted mid-slot with sel=5:
  - Next cycle: sel=0, an=FF, seg=7F, dp=1, frame_tick=0.
